// File: rtl/pool_width_solver.sv
// pool_width_solver: bit-serial inverse of the pool-area function.
// Finds the largest w with f(w) = w*w + floor(CIRC_NUM*w*w >> CIRC_SHIFT) <= A,
// one result bit per clock, MSB first, behind a start/busy/done handshake.
// Optional feature macro: POOL_SOLVER_RANGE_CHK_EN adds the range_err output.
module pool_width_solver #(
  parameter int unsigned W          = 8,
  parameter int unsigned CIRC_NUM   = 201,
  parameter int unsigned CIRC_SHIFT = 8,
  localparam int unsigned AW        = 2 * W + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] area_in,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  width_out,
  output logic          exact
`ifdef POOL_SOLVER_RANGE_CHK_EN
  ,
  output logic          range_err
`endif
);

  localparam int unsigned CW = $clog2(CIRC_NUM + 1);
  localparam int unsigned PW = 2 * W + CW;
  localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Area of a square of side w plus its inscribed circle (monotonic in w).
  function automatic logic [AW-1:0] f_area(input logic [W-1:0] w);
    logic [2*W-1:0] sq;
    logic [PW-1:0]  prod;
    sq   = (2*W)'(w) * (2*W)'(w);
    prod = PW'(sq) * PW'(CIRC_NUM);
    return AW'(sq) + AW'(prod >> CIRC_SHIFT);
  endfunction

`ifdef POOL_SOLVER_RANGE_CHK_EN
  localparam logic [AW-1:0] F_MAX = f_area({W{1'b1}});
`endif

  state_e         state_q, state_d;
  logic [AW-1:0]  tgt_q, tgt_d;
  logic [W-1:0]   res_q, res_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   width_q, width_d;
  logic           exact_q, exact_d;
`ifdef POOL_SOLVER_RANGE_CHK_EN
  logic           range_err_q, range_err_d;
`endif

  logic [W-1:0]   trial_c;
  logic [W-1:0]   res_next_c;
  logic           fits_c;

  // One greedy search step: keep the trial bit if its area still fits.
  always_comb begin
    trial_c    = res_q | (W'(1) << bit_q);
    fits_c     = (f_area(trial_c) <= tgt_q);
    res_next_c = fits_c ? trial_c : res_q;
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    res_d   = res_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    width_d = width_q;
    exact_d = exact_q;
`ifdef POOL_SOLVER_RANGE_CHK_EN
    range_err_d = range_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tgt_d   = area_in;
          res_d   = '0;
          bit_d   = BW'(W - 1);
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        res_d = res_next_c;
        if (bit_q == '0) begin
          width_d = res_next_c;
          exact_d = (f_area(res_next_c) == tgt_q);
`ifdef POOL_SOLVER_RANGE_CHK_EN
          range_err_d = (tgt_q > F_MAX);
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          bit_d = bit_q - BW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any search in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      res_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      width_q <= '0;
      exact_q <= 1'b0;
`ifdef POOL_SOLVER_RANGE_CHK_EN
      range_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      res_q   <= res_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      width_q <= width_d;
      exact_q <= exact_d;
`ifdef POOL_SOLVER_RANGE_CHK_EN
      range_err_q <= range_err_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign width_out = width_q;
  assign exact     = exact_q;
`ifdef POOL_SOLVER_RANGE_CHK_EN
  assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_pool_width_solver.sv
// Directed bench for pool_width_solver with hand-computed expected widths.
module tb_pool_width_solver;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 2 * W + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] area_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  width_out;
  logic          exact;
`ifdef POOL_SOLVER_RANGE_CHK_EN
  logic          range_err;
`endif

  int total = 0;
  int bad   = 0;

  pool_width_solver #(.W(W), .CIRC_NUM(201), .CIRC_SHIFT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .area_in   (area_in),
    .busy      (busy),
    .done      (done),
    .width_out (width_out),
    .exact     (exact)
`ifdef POOL_SOLVER_RANGE_CHK_EN
    ,
    .range_err (range_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One search: pulse start, measure busy length, check result and pulse width.
  task automatic run_one(input string tag, input logic [AW-1:0] a,
                         input int exp_w, input int exp_e);
    int nbusy;
    bit seen;
    area_in = a;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    area_in = ~a;
    nbusy = 0;
    seen  = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    check({tag, "_width"}, 32'(width_out), 32'(exp_w));
    check({tag, "_exact"}, 32'(exact), 32'(exp_e));
`ifdef POOL_SOLVER_RANGE_CHK_EN
    check({tag, "_range_err"}, 32'(range_err), 32'(a > 17'd116079));
`endif
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    int gap;
    int ndone;
    bit seen;

    // Reset held with start asserted: nothing moves.
    rst     = 1'b0;
    start   = 1'b1;
    area_in = 17'd17851;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_width", 32'(width_out), 32'd0);
    check("rst_exact", 32'(exact), 32'd0);
`ifdef POOL_SOLVER_RANGE_CHK_EN
    check("rst_range_err", 32'(range_err), 32'd0);
`endif
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Main function and boundaries.
    run_one("a17851", 17'd17851, 100, 1);
    run_one("a18000", 17'd18000, 100, 0);
    run_one("a18210", 17'd18210, 101, 1);
    run_one("a0", 17'd0, 0, 1);
    run_one("a7", 17'd7, 2, 1);
    run_one("a8", 17'd8, 2, 0);
    run_one("a116079", 17'd116079, 255, 1);
    run_one("a131071", 17'd131071, 255, 0);

    // start held high; area_in changed during CALC must not matter.
    area_in = 17'd17851;
    start   = 1'b1;
    @(negedge clk);
    area_in = 17'd0;
    @(negedge clk);
    check("hold_width_kept", 32'(width_out), 32'd255);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("bb1_seen", 32'(seen), 32'd1);
    check("bb1_width", 32'(width_out), 32'd100);
    check("bb1_exact", 32'(exact), 32'd1);
    gap  = 0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      gap++;
      if (i == 2) check("bb_width_held", 32'(width_out), 32'd100);
      if (done) begin
        seen = 1;
        break;
      end
    end
    start = 1'b0;
    check("bb2_seen", 32'(seen), 32'd1);
    check("bb_period", 32'(gap), 32'd10);
    check("bb2_width", 32'(width_out), 32'd0);
    check("bb2_exact", 32'(exact), 32'd1);
    repeat (3) @(negedge clk);

    // Known nonzero result before the abort test.
    run_one("pre_abort", 17'd18210, 101, 1);

    // Asynchronous reset mid-search.
    area_in = 17'd7;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_width", 32'(width_out), 32'd0);
    check("abort_exact", 32'(exact), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_one("post_abort", 17'd18000, 100, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
